// File: rtl/ctrl_pipeline_if.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipeline_if
// Description : Signal bundle between the MIPS core datapath and the
//               control-pipeline / hazard unit.
//               Carries the decoded ID-stage control bundle, the ID register
//               fields and the EX zero flag into the unit. It carries the
//               staged controls, hazard decisions and forwarding selects
//               back out.
//   master : core side, drives id_* and ex_zero and observes the results.
//   slave  : ctrl_pipeline side.
// Revision    : 1.0  initial release
// ============================================================================
interface ctrl_pipeline_if;

    // Decoder control bundle for the instruction currently in ID
    logic       id_regDst;
    logic       id_jump;
    logic       id_branch;
    logic       id_branchne;
    logic       id_memRead;
    logic       id_memToReg;
    logic       id_regWrite;
    logic       id_ALUSrc;
    logic       id_memWrite;
    logic       id_memWriteSB;
    logic       id_sys;
    logic       id_jr;
    logic       id_jal;
    logic [1:0] id_Shift;
    logic [2:0] id_ALUop;

    // Register fields of the ID instruction
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_rd;

    // ALU zero flag of the instruction in EX
    logic       ex_zero;

    // Staged controls
    logic [20:0] ex_ctrl;
    logic        mem_memRead;
    logic        mem_memWrite;
    logic        mem_memWriteSB;
    logic        wb_regWrite;
    logic        wb_memToReg;
    logic [4:0]  wb_dst;

    // Hazard / forwarding / retirement
    logic        stall;
    logic        flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        sys_retire;

    modport master (
        output id_regDst, id_jump, id_branch, id_branchne, id_memRead,
               id_memToReg, id_regWrite, id_ALUSrc, id_memWrite,
               id_memWriteSB, id_sys, id_jr, id_jal, id_Shift, id_ALUop,
               id_rs, id_rt, id_rd, ex_zero,
        input  ex_ctrl, mem_memRead, mem_memWrite, mem_memWriteSB,
               wb_regWrite, wb_memToReg, wb_dst,
               stall, flush, fwd_a, fwd_b, sys_retire
    );

    modport slave (
        input  id_regDst, id_jump, id_branch, id_branchne, id_memRead,
               id_memToReg, id_regWrite, id_ALUSrc, id_memWrite,
               id_memWriteSB, id_sys, id_jr, id_jal, id_Shift, id_ALUop,
               id_rs, id_rt, id_rd, ex_zero,
        output ex_ctrl, mem_memRead, mem_memWrite, mem_memWriteSB,
               wb_regWrite, wb_memToReg, wb_dst,
               stall, flush, fwd_a, fwd_b, sys_retire
    );

endinterface
`default_nettype wire

// File: rtl/ctrl_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipeline
// Description : Control-bundle carrier and hazard unit for the 5-stage MIPS
//               core. It registers the decoded control bundle through the
//               ID/EX, EX/MEM and MEM/WB boundaries. It detects load-use
//               stalls and branch/jump redirects, produces the EX operand
//               forwarding selects and pulses sys_retire as a syscall
//               leaves WB.
// Ports       :
//   clk   in  core clock, rising edge
//   rst_b in  asynchronous active-low reset (loads a bubble into every stage)
//   bus   slave modport of ctrl_pipeline_if:
//     in : id_* control bundle, id_rs/id_rt/id_rd, ex_zero
//     out: ex_ctrl[20:0], mem_memRead/memWrite/memWriteSB,
//          wb_regWrite/memToReg, wb_dst[4:0], stall, flush,
//          fwd_a[1:0], fwd_b[1:0], sys_retire
//   ex_ctrl packing (MSB..LSB): 3'b000, regDst, jump, branch, branchne,
//          memRead, memToReg, regWrite, ALUSrc, memWrite, memWriteSB,
//          sys, jr, jal, Shift[1:0], ALUop[2:0]
// Revision    : 1.0  initial release
// ============================================================================
module ctrl_pipeline (
    input  logic           clk,
    input  logic           rst_b,
    ctrl_pipeline_if.slave bus
);

    // ------------------------------------------------------------------
    // Bundle layout (18 live bits, padded to 21 on the ex_ctrl output)
    // ------------------------------------------------------------------
    localparam int unsigned c_bundle_w     = 18;
    localparam int unsigned c_b_regdst     = 17;
    localparam int unsigned c_b_jump       = 16;
    localparam int unsigned c_b_branch     = 15;
    localparam int unsigned c_b_branchne   = 14;
    localparam int unsigned c_b_memread    = 13;
    localparam int unsigned c_b_memtoreg   = 12;
    localparam int unsigned c_b_regwrite   = 11;
    localparam int unsigned c_b_memwrite   = 9;
    localparam int unsigned c_b_memwritesb = 8;
    localparam int unsigned c_b_sys        = 7;
    localparam int unsigned c_b_jr         = 6;
    localparam int unsigned c_b_jal        = 5;

    localparam logic [4:0] c_reg_zero = 5'd0;
    localparam logic [4:0] c_reg_ra   = 5'd31;

    localparam logic [1:0] c_fwd_rf  = 2'b00;
    localparam logic [1:0] c_fwd_mem = 2'b10;
    localparam logic [1:0] c_fwd_wb  = 2'b01;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    // ID/EX
    logic [c_bundle_w-1:0] ex_bundle_q, ex_bundle_d;
    logic [4:0]            ex_dst_q,    ex_dst_d;
    logic [4:0]            ex_rs_q,     ex_rs_d;
    logic [4:0]            ex_rt_q,     ex_rt_d;
    // EX/MEM
    logic                  mem_memRead_q;
    logic                  mem_memWrite_q;
    logic                  mem_memWriteSB_q;
    logic                  mem_memToReg_q;
    logic                  mem_regWrite_q;
    logic                  mem_sys_q;
    logic [4:0]            mem_dst_q;
    // MEM/WB
    logic                  wb_regWrite_q;
    logic                  wb_memToReg_q;
    logic                  wb_sys_q;
    logic [4:0]            wb_dst_q;
    // Retirement
    logic                  sys_retire_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [c_bundle_w-1:0] w_id_bundle;
    logic [4:0]            w_id_dst;
    logic                  w_hazard;
    logic                  w_redirect;
    logic                  w_bubble;

    assign w_id_bundle = {bus.id_regDst,   bus.id_jump,     bus.id_branch,
                          bus.id_branchne, bus.id_memRead,  bus.id_memToReg,
                          bus.id_regWrite, bus.id_ALUSrc,   bus.id_memWrite,
                          bus.id_memWriteSB, bus.id_sys,    bus.id_jr,
                          bus.id_jal,      bus.id_Shift,    bus.id_ALUop};

    // Destination of the ID instruction. A non-writing instruction carries
    // dst 0 so that the register fields the decoder leaves undefined for it
    // can never look like a hazard or a forwarding source downstream.
    always_comb begin
        w_id_dst = c_reg_zero;
        if (bus.id_regWrite) begin
            if (bus.id_jal) begin
                w_id_dst = c_reg_ra;
            end else if (bus.id_regDst) begin
                w_id_dst = bus.id_rd;
            end else begin
                w_id_dst = bus.id_rt;
            end
        end
    end

    // Load-use: the load in EX produces its value too late for the
    // instruction in ID, which has to wait one cycle.
    assign w_hazard = ex_bundle_q[c_b_memread] && (ex_dst_q != c_reg_zero) &&
                      ((ex_dst_q == bus.id_rs) || (ex_dst_q == bus.id_rt));

    // Control transfer resolved in EX.
    assign w_redirect = (ex_bundle_q[c_b_branch]   &&  bus.ex_zero) ||
                        (ex_bundle_q[c_b_branchne] && !bus.ex_zero) ||
                         ex_bundle_q[c_b_jump] ||
                         ex_bundle_q[c_b_jr];

    // Both cases insert exactly one bubble. When they coincide the ID
    // instruction is on the wrong path anyway, so the redirect takes the
    // cycle and no stall is requested.
    assign w_bubble = w_hazard || w_redirect;

    always_comb begin
        ex_bundle_d = w_id_bundle;
        ex_dst_d    = w_id_dst;
        ex_rs_d     = bus.id_rs;
        ex_rt_d     = bus.id_rt;
        if (w_bubble) begin
            ex_bundle_d = '0;
            ex_dst_d    = c_reg_zero;
            ex_rs_d     = c_reg_zero;
            ex_rt_d     = c_reg_zero;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers. EX/MEM and MEM/WB never stall.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ex_bundle_q      <= '0;
            ex_dst_q         <= c_reg_zero;
            ex_rs_q          <= c_reg_zero;
            ex_rt_q          <= c_reg_zero;
            mem_memRead_q    <= 1'b0;
            mem_memWrite_q   <= 1'b0;
            mem_memWriteSB_q <= 1'b0;
            mem_memToReg_q   <= 1'b0;
            mem_regWrite_q   <= 1'b0;
            mem_sys_q        <= 1'b0;
            mem_dst_q        <= c_reg_zero;
            wb_regWrite_q    <= 1'b0;
            wb_memToReg_q    <= 1'b0;
            wb_sys_q         <= 1'b0;
            wb_dst_q         <= c_reg_zero;
            sys_retire_q     <= 1'b0;
        end else begin
            ex_bundle_q      <= ex_bundle_d;
            ex_dst_q         <= ex_dst_d;
            ex_rs_q          <= ex_rs_d;
            ex_rt_q          <= ex_rt_d;

            mem_memRead_q    <= ex_bundle_q[c_b_memread];
            mem_memWrite_q   <= ex_bundle_q[c_b_memwrite];
            mem_memWriteSB_q <= ex_bundle_q[c_b_memwritesb];
            mem_memToReg_q   <= ex_bundle_q[c_b_memtoreg];
            mem_regWrite_q   <= ex_bundle_q[c_b_regwrite];
            mem_sys_q        <= ex_bundle_q[c_b_sys];
            mem_dst_q        <= ex_dst_q;

            wb_regWrite_q    <= mem_regWrite_q;
            wb_memToReg_q    <= mem_memToReg_q;
            wb_sys_q         <= mem_sys_q;
            wb_dst_q         <= mem_dst_q;

            sys_retire_q     <= wb_sys_q;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding: the youngest producer (MEM) wins over WB; register 0 is
    // hard-wired and never forwarded.
    // ------------------------------------------------------------------
    function automatic logic [1:0] fwd_select(
        input logic [4:0] src,
        input logic       mem_we,
        input logic [4:0] mem_dst,
        input logic       wb_we,
        input logic [4:0] wb_dst
    );
        logic [1:0] sel;
        sel = c_fwd_rf;
        if (mem_we && (mem_dst != c_reg_zero) && (mem_dst == src)) begin
            sel = c_fwd_mem;
        end else if (wb_we && (wb_dst != c_reg_zero) && (wb_dst == src)) begin
            sel = c_fwd_wb;
        end
        return sel;
    endfunction

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ex_ctrl        = {3'b000, ex_bundle_q};
    assign bus.mem_memRead    = mem_memRead_q;
    assign bus.mem_memWrite   = mem_memWrite_q;
    assign bus.mem_memWriteSB = mem_memWriteSB_q;
    assign bus.wb_regWrite    = wb_regWrite_q;
    assign bus.wb_memToReg    = wb_memToReg_q;
    assign bus.wb_dst         = wb_dst_q;
    assign bus.stall          = w_hazard && !w_redirect;
    assign bus.flush          = w_redirect;
    assign bus.fwd_a          = fwd_select(ex_rs_q, mem_regWrite_q, mem_dst_q,
                                           wb_regWrite_q, wb_dst_q);
    assign bus.fwd_b          = fwd_select(ex_rt_q, mem_regWrite_q, mem_dst_q,
                                           wb_regWrite_q, wb_dst_q);
    assign bus.sys_retire     = sys_retire_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipeline.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ctrl_pipeline
// Description : Self-checking bench for ctrl_pipeline. The stimulus side
//               walks directed and random instruction streams through a
//               stage-level reference model and queues the expected outputs
//               of every cycle. A monitor on the falling edge pops each
//               entry and compares it with the DUT.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ctrl_pipeline;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    ctrl_pipeline_if bus ();

    ctrl_pipeline dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    // ------------------------------------------------------------------
    // Instruction record and reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       regDst, jump, branch, branchne, memRead, memToReg,
                    regWrite, ALUSrc, memWrite, memWriteSB, sys, jr, jal;
        logic [1:0] shift;
        logic [2:0] aluop;
        logic [4:0] rs, rt, rd;
    } instr_t;

    typedef struct {
        logic [20:0] ex_ctrl;
        logic        m_rd, m_wr, m_sb;
        logic        wb_rw, wb_m2r;
        logic [4:0]  wb_dst;
        logic        stall, flush;
        logic [1:0]  fa, fb;
        logic        sysr;
    } exp_t;

    localparam int K_NOP = 0, K_ADD = 1, K_LW = 2, K_SW = 3, K_SB = 4,
                   K_BEQ = 5, K_BNE = 6, K_J = 7, K_JR = 8, K_JAL = 9,
                   K_SYS = 10, K_SLL = 11;

    instr_t m_ex, m_mem, m_wb;
    logic   m_ret;
    exp_t   sb[$];

    int n_checks = 0;
    int n_errors = 0;

    function automatic instr_t mk(int kind, int rs, int rt, int rd);
        instr_t i = '0;
        i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd);
        case (kind)
            K_ADD: begin i.regDst = 1; i.regWrite = 1; i.aluop = 3'($urandom_range(0, 7)); end
            K_LW:  begin i.memRead = 1; i.memToReg = 1; i.regWrite = 1; i.ALUSrc = 1; end
            K_SW:  begin i.memWrite = 1; i.ALUSrc = 1; end
            K_SB:  begin i.memWrite = 1; i.memWriteSB = 1; i.ALUSrc = 1; end
            K_BEQ: begin i.branch = 1; i.aluop = 3'd1; end
            K_BNE: begin i.branchne = 1; i.aluop = 3'd1; end
            K_J:   i.jump = 1;
            K_JR:  i.jr = 1;
            K_JAL: begin i.jal = 1; i.jump = 1; i.regWrite = 1; end
            K_SYS: i.sys = 1;
            K_SLL: begin i.regDst = 1; i.regWrite = 1; i.shift = 2'($urandom_range(1, 3)); end
            default: ;
        endcase
        return i;
    endfunction

    // Architectural destination of an instruction (0 = writes nothing).
    function automatic int dst_of(instr_t i);
        if (!i.regWrite) return 0;
        if (i.jal)       return 31;
        if (i.regDst)    return int'(i.rd);
        return int'(i.rt);
    endfunction

    // Where an EX operand reading register r must come from.
    function automatic logic [1:0] src_of(int r);
        if (dst_of(m_mem) != 0 && dst_of(m_mem) == r) return 2'b10;
        if (dst_of(m_wb)  != 0 && dst_of(m_wb)  == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [20:0] ctrl_word(instr_t i);
        return {3'b000, i.regDst, i.jump, i.branch, i.branchne, i.memRead,
                i.memToReg, i.regWrite, i.ALUSrc, i.memWrite, i.memWriteSB,
                i.sys, i.jr, i.jal, i.shift, i.aluop};
    endfunction

    task automatic drive(instr_t i, logic z);
        bus.id_regDst     = i.regDst;   bus.id_jump     = i.jump;
        bus.id_branch     = i.branch;   bus.id_branchne = i.branchne;
        bus.id_memRead    = i.memRead;  bus.id_memToReg = i.memToReg;
        bus.id_regWrite   = i.regWrite; bus.id_ALUSrc   = i.ALUSrc;
        bus.id_memWrite   = i.memWrite; bus.id_memWriteSB = i.memWriteSB;
        bus.id_sys        = i.sys;      bus.id_jr       = i.jr;
        bus.id_jal        = i.jal;      bus.id_Shift    = i.shift;
        bus.id_ALUop      = i.aluop;
        bus.id_rs = i.rs; bus.id_rt = i.rt; bus.id_rd = i.rd;
        bus.ex_zero = z;
    endtask

    // One clock cycle: present i in ID, queue what the DUT must show in
    // this cycle, then let the model take the rising edge.
    task automatic step(instr_t i, logic z, output logic stalled);
        exp_t e;
        logic taken, loaduse;
        int   ed;
        drive(i, z);
        ed      = dst_of(m_ex);
        taken   = (m_ex.branch && z) || (m_ex.branchne && !z) || m_ex.jump || m_ex.jr;
        loaduse = m_ex.memRead && ed != 0 && (ed == int'(i.rs) || ed == int'(i.rt));
        e.ex_ctrl = ctrl_word(m_ex);
        e.m_rd    = m_mem.memRead;
        e.m_wr    = m_mem.memWrite;
        e.m_sb    = m_mem.memWriteSB;
        e.wb_rw   = m_wb.regWrite;
        e.wb_m2r  = m_wb.memToReg;
        e.wb_dst  = 5'(dst_of(m_wb));
        e.flush   = taken;
        e.stall   = loaduse && !taken;
        e.fa      = src_of(int'(m_ex.rs));
        e.fb      = src_of(int'(m_ex.rt));
        e.sysr    = m_ret;
        sb.push_back(e);
        stalled = e.stall;
        if (rst_b) begin
            m_ret = m_wb.sys;
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (taken || loaduse) ? instr_t'('0) : i;
        end
        @(posedge clk);
        #1;
    endtask

    // Issue an instruction, holding it in ID while the pipeline stalls.
    task automatic issue(instr_t i, logic z);
        logic st;
        for (int k = 0; k < 4; k++) begin
            step(i, z, st);
            if (!st) break;
        end
    endtask

    task automatic model_reset();
        m_ex = '0; m_mem = '0; m_wb = '0; m_ret = 1'b0;
    endtask

    // Assert reset between edges for n cycles while i sits in ID.
    task automatic reset_for(int n, instr_t i);
        logic st;
        rst_b = 1'b0;
        model_reset();
        for (int k = 0; k < n; k++) step(i, 1'b0, st);
        rst_b = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("ex_ctrl",        32'(bus.ex_ctrl),        32'(e.ex_ctrl));
            check("mem_memRead",    32'(bus.mem_memRead),    32'(e.m_rd));
            check("mem_memWrite",   32'(bus.mem_memWrite),   32'(e.m_wr));
            check("mem_memWriteSB", 32'(bus.mem_memWriteSB), 32'(e.m_sb));
            check("wb_regWrite",    32'(bus.wb_regWrite),    32'(e.wb_rw));
            check("wb_memToReg",    32'(bus.wb_memToReg),    32'(e.wb_m2r));
            check("wb_dst",         32'(bus.wb_dst),         32'(e.wb_dst));
            check("stall",          32'(bus.stall),          32'(e.stall));
            check("flush",          32'(bus.flush),          32'(e.flush));
            check("fwd_a",          32'(bus.fwd_a),          32'(e.fa));
            check("fwd_b",          32'(bus.fwd_b),          32'(e.fb));
            check("sys_retire",     32'(bus.sys_retire),     32'(e.sysr));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    instr_t nop;
    instr_t x;

    initial begin
        nop = '0;
        model_reset();
        drive(nop, 1'b0);
        @(posedge clk);
        #1;
        reset_for(2, nop);

        // Mid-stream reset with a register-writing instruction in ID
        issue(mk(K_ADD, 1, 2, 5), 0);
        issue(mk(K_LW, 0, 7, 0), 0);
        reset_for(2, mk(K_ADD, 7, 7, 4));
        issue(mk(K_ADD, 1, 2, 5), 0);
        repeat (4) issue(nop, 0);

        // Load-use followed by WB forwarding
        issue(mk(K_LW, 1, 8, 0), 0);
        issue(mk(K_ADD, 8, 2, 4), 0);
        repeat (3) issue(nop, 0);

        // MEM forwarding, WB forwarding, register 0 never forwards
        issue(mk(K_ADD, 1, 2, 3), 0);
        issue(mk(K_ADD, 3, 3, 6), 0);
        issue(mk(K_ADD, 1, 2, 3), 0);
        issue(nop, 0);
        issue(mk(K_ADD, 3, 3, 6), 0);
        issue(mk(K_ADD, 1, 2, 0), 0);
        issue(mk(K_ADD, 0, 0, 6), 0);
        repeat (3) issue(nop, 0);

        // Branches and jumps resolved in EX
        issue(mk(K_BEQ, 1, 2, 0), 0);
        issue(mk(K_ADD, 1, 2, 7), 1);
        issue(mk(K_BNE, 1, 2, 0), 0);
        issue(mk(K_ADD, 1, 2, 7), 1);
        issue(mk(K_J, 0, 0, 0), 0);
        issue(mk(K_ADD, 1, 2, 7), 0);
        issue(mk(K_JR, 31, 0, 0), 0);
        issue(mk(K_ADD, 1, 2, 7), 0);

        // Redirect and load-use in the same cycle
        x = mk(K_LW, 1, 8, 0);
        x.jump = 1'b1;
        issue(x, 0);
        issue(mk(K_ADD, 8, 8, 9), 0);
        repeat (3) issue(nop, 0);

        // JAL writes r31 regardless of regDst/rd
        x = mk(K_JAL, 0, 0, 9);
        x.regDst = 1'b1;
        issue(x, 0);
        repeat (4) issue(nop, 0);

        // Syscall retirement and stores
        issue(mk(K_SYS, 0, 0, 0), 0);
        issue(mk(K_SW, 1, 2, 0), 0);
        issue(mk(K_SB, 1, 2, 0), 0);
        repeat (5) issue(nop, 0);

        // Random stream over a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            instr_t r;
            r = mk(int'($urandom_range(0, 11)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            if ($urandom_range(0, 99) == 0) reset_for(1, r);
            issue(r, 1'($urandom_range(0, 1)));
        end
        repeat (4) issue(nop, 0);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: got timeout, expected stimulus to complete");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctrl_pipeline.md
# ctrl_pipeline

Pipelined control-bundle carrier and hazard unit for the 5-stage MIPS core. It sits directly downstream of the ID-stage control decoder and consumes its decoded control bundle together with the ID instruction's register fields. It then registers that bundle through the ID/EX, EX/MEM and MEM/WB boundaries. It also resolves load-use stalls, branch/jump redirects and operand forwarding selects, and signals syscall retirement at WB.

## Interface
- No parameters; register-file index width fixed at 5, ALUop 3, Shift 2.
- clk  in  1  core clock; all state updates on rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- id_regDst, id_jump, id_branch, id_branchne, id_memRead, id_memToReg, id_regWrite, id_ALUSrc, id_memWrite, id_memWriteSB, id_sys, id_jr, id_jal  in  1 each  decoder control bundle for the instruction in ID.
- id_Shift  in  2  decoder shift select.
- id_ALUop  in  3  decoder ALU op.
- id_rs, id_rt, id_rd  in  5 each  register fields of the ID instruction.
- ex_zero  in  1  ALU zero flag for the instruction in EX.
- ex_ctrl  out  21  registered bundle in EX, field order as inputs, Shift/ALUop included.
- mem_memRead, mem_memWrite, mem_memWriteSB  out  1 each  MEM-stage memory controls.
- wb_regWrite, wb_memToReg  out  1 each  WB controls.
- wb_dst  out  5  WB destination register.
- stall  out  1  hold PC and IF/ID this cycle.
- flush  out  1  squash IF/ID, redirect PC this cycle.
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 10 from MEM, 01 from WB.
- sys_retire  out  1  one-cycle pulse when a syscall leaves WB.

## Operation
- Bubble = all control bits 0, dst 0. Reset loads a bubble into every stage.
- Destination in EX: jal → 31; else regDst → rd; else rt. If regWrite=0, dst is forced to 0. Decoder x fields are masked to 0 when captured.
- Load-use: stall = ex_memRead & ex_dst≠0 & (ex_dst==id_rs | ex_dst==id_rt). On stall, a bubble enters ID/EX; EX/MEM and MEM/WB always advance.
- Redirect: flush = (ex_branch & ex_zero) | (ex_branchne & ~ex_zero) | ex_jump | ex_jr. On flush, a bubble enters ID/EX regardless of stall, and stall is forced 0 (flush wins).
- Forwarding (combinational from registered state): fwd_a=10 if mem_regWrite & mem_dst≠0 & mem_dst==ex_rs; else 01 if wb_regWrite & wb_dst≠0 & wb_dst==ex_rs; else 00. fwd_b uses the same rule with ex_rt. MEM has priority over WB.
- ex_rs/ex_rt are latched with the bundle; a bubble clears them to 0.
- sys_retire = wb_sys registered; it does not alter stall or flush.

## Timing
- Latency ID→EX 1 cycle, ID→MEM 2, ID→WB 3; sys_retire asserts 4 cycles after syscall is in ID (no stalls).
- stall, flush, fwd_* are combinational from current stage registers and id_* inputs, valid in the same cycle.
- Reset mid-operation: all outputs 0 immediately (asynchronous), including stall/flush (ex_* zero). First post-reset edge captures id_* normally.
- Back-to-back loads each stall at most one cycle; a second stall cannot occur for the same consumer.
- Simultaneous stall condition and flush: flush=1, stall=0, single bubble.

## Test plan
- Reset: drive rst_b=0 mid-stream with id_regWrite=1 → all outputs 0 within the same cycle. After release, an ADD (regDst=1, rd=5) reaches wb_dst=5 with wb_regWrite=1 exactly 3 edges later.
- Load-use: LW rt=8, then ADD rs=8 → stall=1 for one cycle, ex_ctrl=0 next cycle, ADD in EX the following cycle with fwd_a=01.
- Forwarding: ADD rd=3; ADD rs=3, rt=3 → fwd_a=fwd_b=10. With one NOP between them → 01. Dst 0 never forwards.
- Branch: BEQ with ex_zero=1 → flush=1, bubble in ID/EX. BNE with ex_zero=1 → flush=0. J, JR → flush=1. Flush coinciding with a load-use condition → stall=0.
- JAL: jal=1, rd=9 → wb_dst=31, wb_regWrite=1.
- Syscall: sys in ID → sys_retire single-cycle pulse 4 cycles later; SW → mem_memWrite=1 with wb_regWrite=0.
